// File: rtl/uart_block_framer_pkg.sv
// Shared types and helpers for the UART block framer (rx assembly and tx serializer).
package uart_block_pkg;

  localparam int BYTE_W          = 8;
  // Largest block the byte-select helper can address; blocks are zero-extended to this.
  localparam int MAX_BLOCK_BYTES = 64;
  localparam int MAX_BLK_W       = BYTE_W * MAX_BLOCK_BYTES;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } rx_state_e;

  typedef enum logic [0:0] {
    T_IDLE = 1'b0,
    T_SEND = 1'b1
  } tx_state_e;

  // Returns wire-order byte idx of a block of nbytes bytes.
  // msb_first=1: idx 0 is the top byte; msb_first=0: idx 0 is bits [7:0].
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [MAX_BLK_W-1:0] block,
                                                 input logic [31:0]          idx,
                                                 input logic [31:0]          nbytes,
                                                 input logic                 msb_first);
    logic [31:0] pos;
    pos = msb_first ? (nbytes - 32'd1 - idx) : idx;
    return block[pos*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/uart_block_framer_if.sv
// Byte/block bus of the framer: UART rx bytes in, blocks to/from the core, UART tx bytes out.
//
// Handshakes (blk_out, blk_in, tx): a transfer happens on a rising clk edge where both
// valid and ready are high. Once valid rises, the data is held stable and valid stays
// high until that transfer; ready may come before, with, or after valid.
// rx_strobe is not a handshake: it is a one-cycle pulse with no back-pressure.
interface uart_block_framer_if #(
  parameter int BLOCK_BYTES = 8
);
  logic                     rx_strobe;
  logic [7:0]               rx_byte;
  logic [8*BLOCK_BYTES-1:0] blk_out;
  logic                     blk_out_valid;
  logic                     blk_out_ready;
  logic [8*BLOCK_BYTES-1:0] blk_in;
  logic                     blk_in_valid;
  logic                     blk_in_ready;
  logic [7:0]               tx_byte;
  logic                     tx_valid;
  logic                     tx_ready;

  // Framer side.
  modport master (
    input  rx_strobe, rx_byte, blk_out_ready, blk_in, blk_in_valid, tx_ready,
    output blk_out, blk_out_valid, blk_in_ready, tx_byte, tx_valid
  );

  // UART / cipher-core side.
  modport slave (
    output rx_strobe, rx_byte, blk_out_ready, blk_in, blk_in_valid, tx_ready,
    input  blk_out, blk_out_valid, blk_in_ready, tx_byte, tx_valid
  );
endinterface

// File: rtl/uart_block_framer_serializer.sv
// Tx path: accepts one result block and sends it out byte by byte in wire order.
module block_serializer
  import uart_block_pkg::*;
#(
  parameter int BLOCK_BYTES = 8,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*BLOCK_BYTES-1:0]  blk_i,
  input  logic                      blk_valid_i,
  output logic                      blk_ready_o,
  output logic [BYTE_W-1:0]         tx_byte_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output tx_state_e                 state_o
);

  localparam int                BLK_W    = BYTE_W * BLOCK_BYTES;
  localparam int                IDX_W    = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLOCK_BYTES - 1);

  tx_state_e          state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
  logic [MAX_BLK_W-1:0] ext_in, ext_q;

  // Next state: load a block in T_IDLE, step through its bytes in T_SEND.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    tx_byte_d = tx_byte_q;
    ext_in    = '0;
    ext_in[BLK_W-1:0] = blk_i;
    ext_q     = '0;
    ext_q[BLK_W-1:0]  = blk_q;
    case (state_q)
      T_IDLE: begin
        if (blk_valid_i) begin
          blk_d     = blk_i;
          cnt_d     = '0;
          tx_byte_d = sel_byte(ext_in, 32'd0, 32'(BLOCK_BYTES), MSB_FIRST);
          state_d   = T_SEND;
        end
      end
      T_SEND: begin
        if (tx_ready_i) begin
          if (cnt_q == IDX_LAST) begin
            cnt_d   = '0;
            state_d = T_IDLE;
          end else begin
            cnt_d     = cnt_q + IDX_W'(1);
            tx_byte_d = sel_byte(ext_q, 32'(cnt_q) + 32'd1, 32'(BLOCK_BYTES), MSB_FIRST);
          end
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  // State registers; reset abandons any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= T_IDLE;
      cnt_q     <= '0;
      blk_q     <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign blk_ready_o = (state_q == T_IDLE);
  assign tx_valid_o  = (state_q == T_SEND);
  assign tx_byte_o   = tx_byte_q;
  assign state_o     = state_q;

endmodule

// File: rtl/uart_block_framer.sv
// Byte-to-block framer: assembles rx bytes into blocks for the cipher core and hands
// result blocks to the tx serializer. Stale partial rx blocks are dropped after a timeout.
module uart_block_framer
  import uart_block_pkg::*;
#(
  parameter int BLOCK_BYTES    = 8,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_block_framer_if.master   bus,
  output logic [15:0]           blk_count,
  output logic                  overrun,
  output logic                  timeout,
  output rx_state_e             rx_state_o,
  output tx_state_e             tx_state_o
);

  localparam int                BLK_W    = BYTE_W * BLOCK_BYTES;
  localparam int                IDX_W    = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLOCK_BYTES - 1);
  localparam int                TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int                TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_LAST_I[TO_W-1:0];

  rx_state_e               state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  // Holds the first BLOCK_BYTES-1 bytes; the last byte goes straight into blk_out.
  logic [BLK_W-BYTE_W-1:0] asm_q, asm_d;
  logic [BLK_W-1:0]        shifted;
  logic [BLK_W-1:0]        blk_out_q, blk_out_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [TO_W-1:0]         idle_q, idle_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;

  // Rx next state: shift bytes in while filling, hold the block until the core takes it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    blk_out_d = blk_out_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    if (MSB_FIRST) begin
      shifted = {asm_q, bus.rx_byte};
    end else begin
      shifted = {bus.rx_byte, asm_q};
    end
    case (state_q)
      FILL: begin
        if (bus.rx_strobe) begin
          asm_d  = MSB_FIRST ? shifted[BLK_W-BYTE_W-1:0] : shifted[BLK_W-1:BYTE_W];
          idle_d = '0;
          if (idx_q == IDX_LAST) begin
            blk_out_d = shifted;
            idx_d     = '0;
            state_d   = HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (TIMEOUT_CYCLES != 0 && idx_q != '0) begin
          if (idle_q == TO_LAST) begin
            idx_d     = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + TO_W'(1);
          end
        end
      end
      HOLD: begin
        overrun_d = bus.rx_strobe;
        if (bus.blk_out_ready) begin
          state_d = FILL;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Rx registers; reset drops any partial block without pulsing overrun/timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      asm_q     <= '0;
      blk_out_q <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      blk_out_q <= blk_out_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.blk_out       = blk_out_q;
  assign bus.blk_out_valid = (state_q == HOLD);
  assign blk_count         = cnt_q;
  assign overrun           = overrun_q;
  assign timeout           = timeout_q;
  assign rx_state_o        = state_q;

  logic              ser_ready;
  logic [BYTE_W-1:0] ser_byte;
  logic              ser_valid;

  block_serializer #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .MSB_FIRST   (MSB_FIRST)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .blk_i       (bus.blk_in),
    .blk_valid_i (bus.blk_in_valid),
    .blk_ready_o (ser_ready),
    .tx_byte_o   (ser_byte),
    .tx_valid_o  (ser_valid),
    .tx_ready_i  (bus.tx_ready),
    .state_o     (tx_state_o)
  );

  assign bus.blk_in_ready = ser_ready;
  assign bus.tx_byte      = ser_byte;
  assign bus.tx_valid     = ser_valid;

endmodule

// File: tb/tb_uart_block_framer.sv
// Bench for uart_block_framer: instance A (8 bytes, MSB first, timeout 100) and
// instance B (16 bytes, LSB first, no timeout), scoreboard-checked.
module tb_uart_block_framer;
  import uart_block_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  uart_block_framer_if #(.BLOCK_BYTES(8))  a_if ();
  uart_block_framer_if #(.BLOCK_BYTES(16)) b_if ();

  logic [15:0] cnt_a, cnt_b;
  logic        ovr_a, ovr_b, to_a, to_b;
  rx_state_e   rxs_a, rxs_b;
  tx_state_e   txs_a, txs_b;

  uart_block_framer #(.BLOCK_BYTES(8), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst(rst_a), .bus(a_if.master), .blk_count(cnt_a),
    .overrun(ovr_a), .timeout(to_a), .rx_state_o(rxs_a), .tx_state_o(txs_a)
  );

  uart_block_framer #(.BLOCK_BYTES(16), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.master), .blk_count(cnt_b),
    .overrun(ovr_b), .timeout(to_b), .rx_state_o(rxs_b), .tx_state_o(txs_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt_a = 0, to_cnt_a = 0, ovr_cnt_b = 0, to_cnt_b = 0;

  logic [63:0]  exp_blk_a_q[$];
  logic [7:0]   exp_tx_a_q[$];
  logic [127:0] exp_blk_b_q[$];
  logic [7:0]   exp_tx_b_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Monitor: compares every completed handshake against the queues, counts pulses.
  always @(negedge clk) begin
    if (a_if.blk_out_valid && a_if.blk_out_ready) begin
      if (exp_blk_a_q.size() == 0) unexpected("a_blk_out", a_if.blk_out);
      else check("a_blk_out", a_if.blk_out, exp_blk_a_q.pop_front());
    end
    if (a_if.tx_valid && a_if.tx_ready) begin
      if (exp_tx_a_q.size() == 0) unexpected("a_tx_byte", a_if.tx_byte);
      else check("a_tx_byte", a_if.tx_byte, exp_tx_a_q.pop_front());
    end
    if (b_if.blk_out_valid && b_if.blk_out_ready) begin
      if (exp_blk_b_q.size() == 0) unexpected("b_blk_out", b_if.blk_out);
      else check("b_blk_out", b_if.blk_out, exp_blk_b_q.pop_front());
    end
    if (b_if.tx_valid && b_if.tx_ready) begin
      if (exp_tx_b_q.size() == 0) unexpected("b_tx_byte", b_if.tx_byte);
      else check("b_tx_byte", b_if.tx_byte, exp_tx_b_q.pop_front());
    end
    if (ovr_a) ovr_cnt_a++;
    if (to_a)  to_cnt_a++;
    if (ovr_b) ovr_cnt_b++;
    if (to_b)  to_cnt_b++;
  end

  // ---------------- driver tasks ----------------
  // All stimulus changes 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte_a(input logic [7:0] b);
    a_if.rx_strobe = 1'b1;
    a_if.rx_byte   = b;
    step(1);
    a_if.rx_strobe = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] b);
    b_if.rx_strobe = 1'b1;
    b_if.rx_byte   = b;
    step(1);
    b_if.rx_strobe = 1'b0;
  endtask

  task automatic accept_a();
    a_if.blk_out_ready = 1'b1;
    step(1);
    a_if.blk_out_ready = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_blk_out_valid"}, a_if.blk_out_valid, 1'b0);
    check({tag, "_blk_out"},       a_if.blk_out,       64'h0);
    check({tag, "_blk_in_ready"},  a_if.blk_in_ready,  1'b1);
    check({tag, "_tx_valid"},      a_if.tx_valid,      1'b0);
    check({tag, "_tx_byte"},       a_if.tx_byte,       8'h00);
    check({tag, "_blk_count"},     cnt_a,              16'd0);
    check({tag, "_overrun"},       ovr_a,              1'b0);
    check({tag, "_timeout"},       to_a,               1'b0);
  endtask

  // Watchdog: the directed sequence is a few thousand cycles at most.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got %0t expected under 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int o0, t0;
    a_if.rx_strobe = 1'b0; a_if.rx_byte = '0; a_if.blk_out_ready = 1'b0;
    a_if.blk_in = '0; a_if.blk_in_valid = 1'b0; a_if.tx_ready = 1'b0;
    b_if.rx_strobe = 1'b0; b_if.rx_byte = '0; b_if.blk_out_ready = 1'b0;
    b_if.blk_in = '0; b_if.blk_in_valid = 1'b0; b_if.tx_ready = 1'b0;

    step(3);
    check_reset_a("rst");
    check("rst_b_blk_in_ready", b_if.blk_in_ready, 1'b1);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // A: bytes 01..08, MSB first.
    exp_blk_a_q.push_back(64'h0102030405060708);
    for (int i = 0; i < 7; i++) send_byte_a(8'(i + 1));
    check("a_valid_before_last", a_if.blk_out_valid, 1'b0);
    send_byte_a(8'h08);
    check("a_valid_after_last", a_if.blk_out_valid, 1'b1);
    accept_a();
    check("a_blk_count_1", cnt_a, 16'd1);
    check("a_valid_dropped", a_if.blk_out_valid, 1'b0);

    // A: overruns while holding, including a strobe in the accept cycle.
    exp_blk_a_q.push_back(64'h1112131415161718);
    for (int i = 0; i < 8; i++) send_byte_a(8'(8'h11 + i));
    o0 = ovr_cnt_a;
    for (int i = 0; i < 3; i++) send_byte_a(8'hEE);
    step(1);
    check("a_overrun_3", ovr_cnt_a - o0, 3);
    check("a_blk_out_held", a_if.blk_out, 64'h1112131415161718);
    a_if.blk_out_ready = 1'b1;
    a_if.rx_strobe = 1'b1;
    a_if.rx_byte = 8'hEE;
    step(1);
    a_if.blk_out_ready = 1'b0;
    a_if.rx_strobe = 1'b0;
    step(1);
    check("a_overrun_accept_cycle", ovr_cnt_a - o0, 4);
    check("a_blk_count_2", cnt_a, 16'd2);

    // A: 3 bytes then 100 idle cycles -> one timeout, then a clean block.
    t0 = to_cnt_a;
    send_byte_a(8'h55); send_byte_a(8'h66); send_byte_a(8'h77);
    step(100);
    step(1);
    check("a_timeout_once", to_cnt_a - t0, 1);
    exp_blk_a_q.push_back(64'hAAABACADAEAFB0B1);
    for (int i = 0; i < 8; i++) send_byte_a(8'(8'hAA + i));
    accept_a();
    check("a_blk_count_3", cnt_a, 16'd3);

    // A: strobe in the expiry cycle wins, no timeout.
    t0 = to_cnt_a;
    exp_blk_a_q.push_back(64'h0102030405060708);
    send_byte_a(8'h01);
    step(99);
    for (int i = 1; i < 8; i++) send_byte_a(8'(i + 1));
    check("a_valid_after_expiry_strobe", a_if.blk_out_valid, 1'b1);
    accept_a();
    step(2);
    check("a_no_timeout_at_expiry", to_cnt_a - t0, 0);

    // A: tx with tx_ready toggling 1010 -> 8 bytes in 15 cycles.
    for (int i = 0; i < 8; i++) exp_tx_a_q.push_back(8'(8'h88 + i * 8'h11));
    a_if.blk_in = 64'h8899AABBCCDDEEFF;
    a_if.blk_in_valid = 1'b1;
    step(1);
    a_if.blk_in_valid = 1'b0;
    check("a_tx_valid_rise", a_if.tx_valid, 1'b1);
    check("a_tx_first_byte", a_if.tx_byte, 8'h88);
    for (int i = 0; i < 15; i++) begin
      a_if.tx_ready = (i % 2 == 0);
      check("a_blk_in_ready_low", a_if.blk_in_ready, 1'b0);
      step(1);
    end
    a_if.tx_ready = 1'b0;
    check("a_blk_in_ready_back", a_if.blk_in_ready, 1'b1);
    check("a_tx_valid_done", a_if.tx_valid, 1'b0);
    check("a_tx_queue_drained", exp_tx_a_q.size(), 0);

    // B: 16 bytes LSB first, ready already high when valid rises.
    b_if.blk_out_ready = 1'b1;
    exp_blk_b_q.push_back(128'h100F0E0D0C0B0A090807060504030201);
    for (int i = 0; i < 16; i++) send_byte_b(8'(i + 1));
    check("b_valid_after_last", b_if.blk_out_valid, 1'b1);
    check("b_blk_out_low_byte", b_if.blk_out[7:0], 8'h01);
    check("b_blk_out_high_byte", b_if.blk_out[127:120], 8'h10);
    step(1);
    check("b_blk_count_1", cnt_b, 16'd1);
    check("b_valid_dropped", b_if.blk_out_valid, 1'b0);

    // B: return block sent back-to-back while a second rx block is assembled.
    for (int i = 0; i < 16; i++) exp_tx_b_q.push_back(8'(i + 1));
    exp_blk_b_q.push_back(128'h302F2E2D2C2B2A292827262524232221);
    fork
      begin
        for (int i = 0; i < 16; i++) send_byte_b(8'(8'h21 + i));
      end
      begin
        b_if.blk_in = 128'h100F0E0D0C0B0A090807060504030201;
        b_if.blk_in_valid = 1'b1;
        step(1);
        b_if.blk_in_valid = 1'b0;
        b_if.tx_ready = 1'b1;
        check("b_tx_first_byte", b_if.tx_byte, 8'h01);
        step(15);
        check("b_blk_in_ready_low", b_if.blk_in_ready, 1'b0);
        step(1);
        check("b_blk_in_ready_back", b_if.blk_in_ready, 1'b1);
        b_if.tx_ready = 1'b0;
      end
    join
    check("b_blk_count_2", cnt_b, 16'd2);

    // A: reset after 5 rx bytes and in the middle of a tx block.
    for (int i = 0; i < 5; i++) send_byte_a(8'(8'hC1 + i));
    exp_tx_a_q.push_back(8'h00);
    exp_tx_a_q.push_back(8'h11);
    a_if.blk_in = 64'h0011223344556677;
    a_if.blk_in_valid = 1'b1;
    step(1);
    a_if.blk_in_valid = 1'b0;
    a_if.tx_ready = 1'b1;
    step(2);
    a_if.tx_ready = 1'b0;
    o0 = ovr_cnt_a;
    t0 = to_cnt_a;
    rst_a = 1'b1;
    step(1);
    check_reset_a("midrst");
    step(1);
    rst_a = 1'b0;
    step(2);
    check("midrst_no_overrun", ovr_cnt_a - o0, 0);
    check("midrst_no_timeout", to_cnt_a - t0, 0);
    check("midrst_tx_idle", a_if.tx_valid, 1'b0);
    exp_blk_a_q.push_back(64'hD1D2D3D4D5D6D7D8);
    for (int i = 0; i < 8; i++) send_byte_a(8'(8'hD1 + i));
    check("midrst_valid_after_full", a_if.blk_out_valid, 1'b1);
    accept_a();
    check("midrst_blk_count_1", cnt_a, 16'd1);

    step(3);
    check("a_blk_queue_drained", exp_blk_a_q.size(), 0);
    check("a_tx_queue_drained_end", exp_tx_a_q.size(), 0);
    check("b_blk_queue_drained", exp_blk_b_q.size(), 0);
    check("b_tx_queue_drained", exp_tx_b_q.size(), 0);
    check("b_no_overrun", ovr_cnt_b, 0);
    check("b_no_timeout", to_cnt_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_block_framer.md
# uart_block_framer

Parametrised byte-to-block framer between the UART byte links and a block-cipher core. It gathers `BLOCK_BYTES` received bytes into one block and hands it to the core over a valid/ready handshake. It accepts the core's result block and serialises it back to the UART transmitter. It replaces hard-coded 8-byte/DES framing with configurable block width, byte order and an inter-byte timeout that discards stale partial blocks.

## Interface
- `BLOCK_BYTES`, 8 — bytes per block, ≥2.
- `MSB_FIRST`, 1 — 1: first byte on the wire is block bits [8*BB-1:8*BB-8]; 0: first byte is bits [7:0]. Applies to both directions.
- `TIMEOUT_CYCLES`, 1_000_000 — idle clocks after which a partial rx block is discarded; 0 disables the timeout.
- `clk` in 1 — system clock.
- `rst` in 1 — reset, synchronous, active-high.
- `rx_strobe` in 1 — one-cycle pulse: `rx_byte` is valid.
- `rx_byte` in 8 — received byte.
- `blk_out` out 8*BLOCK_BYTES — assembled block to the core.
- `blk_out_valid` out 1 — `blk_out` is held stable until accepted.
- `blk_out_ready` in 1 — core accepts the block.
- `blk_in` in 8*BLOCK_BYTES — result block from the core.
- `blk_in_valid` in 1 — result available.
- `blk_in_ready` out 1 — framer can take a result.
- `tx_byte` out 8 — byte to the UART transmitter.
- `tx_valid` out 1 — `tx_byte` is valid.
- `tx_ready` in 1 — transmitter accepts the byte.
- `blk_count` out 16 — blocks delivered to the core; wraps.
- `overrun` out 1 — one-cycle pulse: a byte was dropped.
- `timeout` out 1 — one-cycle pulse: a partial block was discarded.

## Operation
- Rx FSM states: `FILL`, `HOLD`.
- In `FILL`, each `rx_strobe` shifts `rx_byte` into the assembly register and increments `byte_idx` (width clog2(BLOCK_BYTES)).
- On the strobe carrying byte BLOCK_BYTES-1: latch the complete block into `blk_out`, clear `byte_idx`, go to `HOLD`.
- In `HOLD`, `blk_out_valid`=1. When `blk_out_valid && blk_out_ready`: return to `FILL` and increment `blk_count` modulo 2^16.
- `rx_strobe` during `HOLD`: byte dropped, `overrun` pulses, FSM unchanged.
- Timeout applies only in `FILL` with `byte_idx`≠0. The idle counter restarts on every strobe. When it reaches TIMEOUT_CYCLES: `byte_idx`←0, `timeout` pulses. A strobe in the same cycle as expiry wins: byte accepted, no timeout.
- Tx FSM states: `T_IDLE`, `T_SEND`.
- In `T_IDLE`, `blk_in_ready`=1. On `blk_in_valid && blk_in_ready`: latch `blk_in`, byte counter←0, go to `T_SEND`.
- In `T_SEND`: `tx_valid`=1 and `tx_byte` = current byte in `MSB_FIRST` order. Each `tx_valid && tx_ready` advances the counter. Acceptance of byte BLOCK_BYTES-1 returns the FSM to `T_IDLE`.
- The rx and tx paths are independent. A new block may be assembled while a result is being sent.

## Timing
- Reset values: `blk_out_valid`=0, `blk_out`=0, `blk_in_ready`=1, `tx_valid`=0, `tx_byte`=0, `blk_count`=0, `overrun`=0, `timeout`=0. Both FSMs reset to `FILL`/`T_IDLE`, with indices and the idle counter at 0.
- `blk_out_valid` rises the cycle after the final byte strobe.
- Ready may be asserted the same cycle valid rises; `FILL` resumes the next cycle. A strobe arriving in the accept cycle is still an overrun.
- `tx_valid` rises the cycle after the `blk_in` handshake. Each byte needs at least one cycle, and back-to-back `tx_ready` gives one byte per clock.
- `blk_in_ready` is high again the cycle after the final tx handshake.
- `rst` mid-operation:
  - Partial blocks and any in-flight tx block are abandoned.
  - Outputs return to reset values on the next edge.
  - No `overrun` or `timeout` pulse is generated by the reset.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `uart_block_pkg`:
  - rx state enum and tx state enum.
  - `BYTE_W`=8.
  - Byte-select function `sel_byte(block, idx, msb_first)`, used by both directions.
- One sub-module, `block_serializer`: the tx FSM, parametrised identically. The rx assembly stays in the top module.

## Test plan
- BB=8, MSB_FIRST=1: bytes 01..08 -> `blk_out`=64'h0102030405060708, valid one cycle after the 8th strobe, `blk_count`=1 after ready.
- BB=16, MSB_FIRST=0: same byte sequence 01..10 -> `blk_out`[7:0]=01 and [127:120]=10. Return path: `blk_in`=128'h1000…0201 -> tx bytes 01,02,…,10 in order.
- Ready held low, 3 extra strobes during `HOLD` -> 3 `overrun` pulses, `blk_out` unchanged.
- TIMEOUT_CYCLES=100: send 3 bytes then idle 100 cycles -> `timeout` pulses once. The next 8 bytes AA..B1 form `blk_out`=64'hAAAB…B1. A strobe exactly at expiry -> no pulse.
- `tx_ready` toggling 1010… with BB=8 -> 8 bytes sent in 15 cycles, `blk_in_ready` low throughout, high on the next cycle.
- `rst` asserted after 5 rx bytes and mid-tx -> all outputs at reset values. The next full block is assembled correctly from a fresh start.
